// File: rtl/model_buffer.sv
// Triangle store for all scene models: streaming loader plus a 1-cycle (model, triangle) read port.
// Optional MODELBUF_DROP_COUNT_EN adds a saturating drop_count output for swallowed read requests.
package model_buffer_pkg;
  typedef logic [15:0] short_t;

  typedef struct packed {
    short_t x;
    short_t y;
    short_t z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

  typedef struct packed {
    short_t model_index;
    short_t triangle_index;
  } modelbuf_read_t;
endpackage

module model_buffer
  import model_buffer_pkg::*;
#(
  parameter int MAX_MODEL_COUNT    = 10,
  parameter int MAX_TRIANGLE_COUNT = 100,
  localparam int MW = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1,
  localparam int AW = (MAX_TRIANGLE_COUNT > 1) ? $clog2(MAX_TRIANGLE_COUNT) : 1,
  localparam int PW = $clog2(MAX_TRIANGLE_COUNT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           write_in_valid,
  output logic           write_in_ready,
  input  logic [MW-1:0]  write_in_model_id,
  input  triangle_t      write_in_triangle,
  input  logic           write_in_last,
  input  logic           read_in_valid,
  output logic           read_in_ready,
  input  modelbuf_read_t read_in_data,
  output logic           triangle_out_valid,
  input  logic           triangle_out_ready,
  output triangle_t      triangle_out_data,
  output triangle_meta_t triangle_out_metadata,
`ifdef MODELBUF_DROP_COUNT_EN
  output logic [15:0]    drop_count,
`endif
  output logic           overflow
);

  typedef enum logic {
    S_IDLE,
    S_LOADING
  } wstate_e;

  wstate_e        state_q, state_d;
  logic           live_q;
  logic [MW-1:0]  slot_q, slot_d;
  logic [PW-1:0]  base_tmp_q, base_tmp_d;
  logic [15:0]    n_q, n_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           overflow_q, overflow_d;

  logic [15:0]    count_q [MAX_MODEL_COUNT];
  logic [AW-1:0]  base_q  [MAX_MODEL_COUNT];
  triangle_t      mem     [MAX_TRIANGLE_COUNT];

  logic           out_valid_q, out_valid_d;
  logic           last_q, last_d;
  triangle_t      data_q;

  logic           beat;
  logic           has_space;
  logic           mem_we;
  logic           commit;
  logic [MW-1:0]  cur_slot;
  logic [PW-1:0]  cur_base;
  logic [15:0]    cur_n;
  logic [15:0]    n_after;
  logic [MAX_MODEL_COUNT-1:0] commit_sel;
  logic [MAX_MODEL_COUNT-1:0] rd_match;

  logic           rd_accept;
  logic           rd_hit;
  logic           rd_last;
  logic [15:0]    sel_count;
  logic [AW-1:0]  sel_base;
  logic [AW-1:0]  rd_addr;

  assign write_in_ready = live_q;
  assign read_in_ready  = live_q && (!out_valid_q || triangle_out_ready);
  assign beat           = write_in_valid && live_q;
  assign has_space      = (wr_ptr_q < PW'(MAX_TRIANGLE_COUNT));

  // Per-slot decode for table commit and read lookup.
  for (genvar gi = 0; gi < MAX_MODEL_COUNT; gi++) begin : g_slot
    assign commit_sel[gi] = (cur_slot == MW'(gi));
    assign rd_match[gi]   = (read_in_data.model_index == 16'(gi));
  end

  // Write FSM: next state and write datapath.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    base_tmp_d = base_tmp_q;
    n_d        = n_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    commit     = 1'b0;
    cur_slot   = (state_q == S_IDLE) ? write_in_model_id : slot_q;
    cur_base   = (state_q == S_IDLE) ? wr_ptr_q : base_tmp_q;
    cur_n      = (state_q == S_IDLE) ? 16'd0 : n_q;
    n_after    = cur_n + (has_space ? 16'd1 : 16'd0);
    if (clear) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      n_d        = '0;
      overflow_d = 1'b0;
    end else if (beat) begin
      slot_d     = cur_slot;
      base_tmp_d = cur_base;
      n_d        = n_after;
      if (has_space) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
      if (write_in_last) begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_LOADING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      live_q     <= 1'b0;
      slot_q     <= '0;
      base_tmp_q <= '0;
      n_q        <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      slot_q     <= slot_d;
      base_tmp_q <= base_tmp_d;
      n_q        <= n_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // A slot's table entry changes only on its last beat, so half-loaded models read as before.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < MAX_MODEL_COUNT; i++) begin
        count_q[i] <= '0;
        base_q[i]  <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < MAX_MODEL_COUNT; i++) begin
        if (commit_sel[i]) begin
          count_q[i] <= n_after;
          base_q[i]  <= AW'(cur_base);
        end
      end
    end
  end

  always_comb begin
    sel_count = '0;
    sel_base  = '0;
    for (int i = 0; i < MAX_MODEL_COUNT; i++) begin
      if (rd_match[i]) begin
        sel_count = count_q[i];
        sel_base  = base_q[i];
      end
    end
  end

  assign rd_accept = read_in_valid && read_in_ready && !clear;
  assign rd_hit    = rd_accept && (|rd_match) && (read_in_data.triangle_index < sel_count);
  assign rd_last   = (read_in_data.triangle_index == sel_count - 16'd1);
  assign rd_addr   = sel_base + AW'(read_in_data.triangle_index);

  always_comb begin
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (clear) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end else if (rd_hit) begin
      out_valid_d = 1'b1;
      last_d      = rd_last;
    end else if (triangle_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  // Triangle RAM with registered read; the read register doubles as the output register.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[AW'(wr_ptr_q)] <= write_in_triangle;
    end
    if (rd_hit) begin
      data_q <= mem[rd_addr];
    end
  end

  assign triangle_out_valid         = out_valid_q;
  assign triangle_out_data          = data_q;
  assign triangle_out_metadata.last = last_q;
  assign overflow                   = overflow_q;

`ifdef MODELBUF_DROP_COUNT_EN
  logic        rd_drop;
  logic [15:0] drop_count_q;

  assign rd_drop = rd_accept && !rd_hit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_count_q <= '0;
    end else if (rd_drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule
